// File: rtl/data_aligner_nch.sv
// N-channel data aligner: one FIFO per channel; one beat leaves once every channel holds a word.
// Define DATA_ALIGNER_NCH_OVF_EN to add sticky per-channel overflow flags (ovf_o, ovf_clr_i).
//
// state | meaning
// IDLE  | data_o not valid, waiting for every channel to hold a word
// VALID | data_o holds a beat waiting for rdy_i
module data_aligner_nch #(
    parameter int WIDTH_FIFO = 8,
    parameter int DEPTH      = 8,
    parameter int N_CH       = 4
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic [N_CH*WIDTH_FIFO-1:0] data_i,
    input  logic [N_CH-1:0]            vld_i,
    input  logic                       rdy_i,
    output logic [N_CH*WIDTH_FIFO-1:0] data_o,
    output logic                       vld_o,
    output logic [N_CH-1:0]            full_o,
    output logic [N_CH-1:0]            empty_o
`ifdef DATA_ALIGNER_NCH_OVF_EN
    ,
    output logic [N_CH-1:0]            ovf_o,
    input  logic                       ovf_clr_i
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH_FIFO-1:0]      mem_q  [N_CH][DEPTH];
    logic [CW-1:0]              cnt_q  [N_CH];
    logic [CW-1:0]              cnt_d  [N_CH];
    logic [AW-1:0]              wptr_q [N_CH];
    logic [AW-1:0]              wptr_d [N_CH];
    logic [AW-1:0]              rptr_q [N_CH];
    logic [AW-1:0]              rptr_d [N_CH];
    logic [N_CH*WIDTH_FIFO-1:0] data_q, data_d;
    logic [N_CH*WIDTH_FIFO-1:0] head;
    logic [N_CH-1:0]            wr_en;
    logic                       pop;

    always_comb begin
        full_o  = '0;
        empty_o = '0;
        for (int k = 0; k < N_CH; k++) begin
            full_o[k]  = (cnt_q[k] == DEPTH_C);
            empty_o[k] = (cnt_q[k] == '0);
        end
    end

    always_comb begin
        head = '0;
        for (int k = 0; k < N_CH; k++) begin
            head[k*WIDTH_FIFO +: WIDTH_FIFO] = mem_q[k][rptr_q[k]];
        end
    end

    // A full channel may still accept a word when the same edge pops it,
    // which puts rdy_i on a combinational path to the write enables.
    always_comb begin
        pop = (~|empty_o) && ((state_q == ST_IDLE) || rdy_i);
        wr_en = '0;
        for (int k = 0; k < N_CH; k++) begin
            wr_en[k] = vld_i[k] && (!full_o[k] || pop);
        end
    end

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            cnt_d[k]  = cnt_q[k] + CW'(wr_en[k]) - CW'(pop);
            wptr_d[k] = wr_en[k] ? wptr_q[k] + AW'(1) : wptr_q[k];
            rptr_d[k] = pop ? rptr_q[k] + AW'(1) : rptr_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (pop) begin
            data_d = head;
        end
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (rdy_i && !pop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k]  <= '0;
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k]  <= cnt_d[k];
                wptr_q[k] <= wptr_d[k];
                rptr_q[k] <= rptr_d[k];
            end
        end
    end

    // Storage needs no reset: counts and pointers define which words are live.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (wr_en[k]) begin
                mem_q[k][wptr_q[k]] <= data_i[k*WIDTH_FIFO +: WIDTH_FIFO];
            end
        end
    end

    assign data_o = data_q;
    assign vld_o  = (state_q == ST_VALID);

`ifdef DATA_ALIGNER_NCH_OVF_EN
    logic [N_CH-1:0] ovf_q;
    logic [N_CH-1:0] drop;

    assign drop = vld_i & ~wr_en;

    // A drop in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= drop | (ovf_q & ~{N_CH{ovf_clr_i}});
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_data_aligner_nch.sv
// Bench for data_aligner_nch: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_data_aligner_nch;

    localparam int W = 8;
    localparam int D = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           aresetn;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   vld_i;
    logic           rdy_i;
    logic           ovf_clr_i;
    logic [N*W-1:0] data_o;
    logic           vld_o;
    logic [N-1:0]   full_o;
    logic [N-1:0]   empty_o;
`ifdef DATA_ALIGNER_NCH_OVF_EN
    logic [N-1:0]   ovf_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    data_aligner_nch #(.WIDTH_FIFO(W), .DEPTH(D), .N_CH(N)) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .data_i   (data_i),
        .vld_i    (vld_i),
        .rdy_i    (rdy_i),
        .data_o   (data_o),
        .vld_o    (vld_o),
        .full_o   (full_o),
        .empty_o  (empty_o)
`ifdef DATA_ALIGNER_NCH_OVF_EN
        ,
        .ovf_o    (ovf_o),
        .ovf_clr_i(ovf_clr_i)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel plus the output beat.
    logic [W-1:0]   mq [N][$];
    logic [N*W-1:0] data_m;
    logic           vld_m;
    logic [N-1:0]   ovf_m;
    int             sz [N];
    bit             pop_m;
    logic [N-1:0]   drop_m;
    logic [N*W-1:0] beat_m;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            data_m <= '0;
            vld_m  <= 1'b0;
            ovf_m  <= '0;
        end else begin
            pop_m  = 1'b1;
            drop_m = '0;
            beat_m = data_m;
            for (int k = 0; k < N; k++) begin
                sz[k] = mq[k].size();
                if (sz[k] == 0) pop_m = 1'b0;
            end
            if (vld_m && !rdy_i) pop_m = 1'b0;
            if (pop_m) begin
                for (int k = 0; k < N; k++) beat_m[k*W +: W] = mq[k].pop_front();
                data_m <= beat_m;
                vld_m  <= 1'b1;
            end else if (rdy_i) begin
                vld_m <= 1'b0;
            end
            for (int k = 0; k < N; k++) begin
                if (vld_i[k]) begin
                    if (sz[k] < D || pop_m) mq[k].push_back(data_i[k*W +: W]);
                    else drop_m[k] = 1'b1;
                end
            end
            ovf_m <= drop_m | (ovf_m & ~{N{ovf_clr_i}});
        end
    end

    logic [N-1:0] exp_full, exp_empty;

    always @(negedge clk) begin
        if (chk_en && aresetn) begin
            for (int k = 0; k < N; k++) begin
                exp_full[k]  = (mq[k].size() == D);
                exp_empty[k] = (mq[k].size() == 0);
            end
            check("mdl_vld_o",   vld_o,   vld_m);
            check("mdl_data_o",  data_o,  data_m);
            check("mdl_full_o",  full_o,  exp_full);
            check("mdl_empty_o", empty_o, exp_empty);
`ifdef DATA_ALIGNER_NCH_OVF_EN
            check("mdl_ovf_o",   ovf_o,   ovf_m);
`endif
        end
    end

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
        vld_i  = v;
        data_i = d;
        rdy_i  = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [N*W-1:0] mk(input int j);
        logic [N*W-1:0] b;
        for (int k = 0; k < N; k++) b[k*W +: W] = 8'(8'h80 | (k << 4) | j);
        return b;
    endfunction

    function automatic logic [N*W-1:0] rnd_beat();
        logic [N*W-1:0] b;
        for (int k = 0; k < N; k++) b[k*W +: W] = 8'($urandom);
        return b;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn   = 1'b0;
        vld_i     = '0;
        data_i    = '0;
        rdy_i     = 1'b0;
        ovf_clr_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_vld_o",   vld_o,   1'b0);
        check("rst_data_o",  data_o,  32'h0);
        check("rst_full_o",  full_o,  4'h0);
        check("rst_empty_o", empty_o, 4'hF);
        aresetn = 1'b1;
        chk_en  = 1'b1;

        // Skew absorption
        for (int i = 0; i < 3; i++) step(4'b0001, {24'h0, 8'(8'h11 + i)}, 1'b1);
        step(4'b1110, 32'h41312100, 1'b1);
        check("skew_vld_c3", vld_o, 1'b0);
        step(4'b1110, 32'h42322200, 1'b1);
        check("skew_vld_c4",  vld_o,  1'b1);
        check("skew_beat0",   data_o, 32'h41312111);
        check("skew_model0",  data_m, 32'h41312111);
        step(4'b1110, 32'h43332300, 1'b1);
        check("skew_beat1",   data_o, 32'h42322212);
        step(4'b0000, 32'h0, 1'b1);
        check("skew_beat2",   data_o, 32'h43332313);
        check("skew_model2",  data_m, 32'h43332313);
        step(4'b0000, 32'h0, 1'b1);
        check("skew_vld_end", vld_o, 1'b0);

        // Backpressure
        step(4'hF, mk(0), 1'b0);
        step(4'hF, mk(1), 1'b0);
        step(4'hF, mk(2), 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'h0, 32'h0, 1'b0);
            check("bp_hold_vld",  vld_o,  1'b1);
            check("bp_hold_data", data_o, 32'hB0A09080);
        end
        step(4'h0, 32'h0, 1'b1);
        check("bp_beat1", data_o, 32'hB1A19181);
        step(4'h0, 32'h0, 1'b1);
        check("bp_beat2", data_o, 32'hB2A29282);
        step(4'h0, 32'h0, 1'b1);
        check("bp_vld_end", vld_o, 1'b0);

        // Full and drop on channel 0
        for (int i = 0; i < 10; i++) begin
            step(4'b0001, {24'h0, 8'(8'h50 + i)}, 1'b1);
            if (i == 6) check("drop_full_7", full_o, 4'b0000);
            if (i == 7) check("drop_full_8", full_o, 4'b0001);
        end
        check("drop_empty", empty_o, 4'b1110);
`ifdef DATA_ALIGNER_NCH_OVF_EN
        check("drop_ovf_set", ovf_o, 4'b0001);
        ovf_clr_i = 1'b1;
        step(4'h0, 32'h0, 1'b1);
        ovf_clr_i = 1'b0;
        check("drop_ovf_clr", ovf_o, 4'b0000);
`endif

        // Empty boundary: channel 1 empty, others full
        for (int i = 0; i < 8; i++) step(4'b1100, {8'(8'h90 + i), 8'(8'h70 + i), 16'h0}, 1'b1);
        check("eb_full",  full_o,  4'b1101);
        check("eb_empty", empty_o, 4'b0010);
        for (int i = 0; i < 2; i++) begin
            step(4'h0, 32'h0, 1'b1);
            check("eb_no_vld", vld_o, 1'b0);
        end
        step(4'b0010, 32'h00006600, 1'b1);
        check("eb_vld_wr", vld_o, 1'b0);
        step(4'h0, 32'h0, 1'b1);
        check("eb_vld",  vld_o,  1'b1);
        check("eb_beat", data_o, 32'h90706650);

        // Refill everything, then write into full FIFOs while popping
        step(4'hF, 32'hA3A2C0A0, 1'b0);
        for (int i = 1; i < 8; i++) step(4'b0010, {16'h0, 8'(8'hC0 + i), 8'h0}, 1'b0);
        check("fp_all_full", full_o, 4'hF);
        for (int i = 0; i < 10; i++) begin
            step(4'hF, rnd_beat(), 1'b1);
            check("fp_full", full_o, 4'hF);
            check("fp_vld",  vld_o,  1'b1);
`ifdef DATA_ALIGNER_NCH_OVF_EN
            check("fp_ovf",  ovf_o,  4'h0);
`endif
        end

        // Randomized traffic with varying load
        for (int seg = 0; seg < 15; seg++) begin
            int pv, pr;
            pv = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
            for (int i = 0; i < 200; i++) begin
                logic [N-1:0] v;
                for (int k = 0; k < N; k++) v[k] = ($urandom_range(0, 99) < pv);
                ovf_clr_i = ($urandom_range(0, 99) < 5);
                step(v, rnd_beat(), ($urandom_range(0, 99) < pr));
            end
        end
        ovf_clr_i = 1'b0;

        // Reset mid-stream
        for (int i = 0; i < 20; i++) step(4'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'hF, rnd_beat(), 1'b0);
        check("mr_vld_before", vld_o, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        check("mr_vld_o",   vld_o,   1'b0);
        check("mr_data_o",  data_o,  32'h0);
        check("mr_full_o",  full_o,  4'h0);
        check("mr_empty_o", empty_o, 4'hF);
`ifdef DATA_ALIGNER_NCH_OVF_EN
        check("mr_ovf_o",   ovf_o,   4'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        step(4'hF, 32'h0D0C0B0A, 1'b1);
        check("mr_vld_wr", vld_o, 1'b0);
        step(4'h0, 32'h0, 1'b1);
        check("mr_vld_post",  vld_o,  1'b1);
        check("mr_beat_post", data_o, 32'h0D0C0B0A);
        step(4'h0, 32'h0, 1'b1);
        check("mr_vld_end", vld_o, 1'b0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_aligner_nch.md
# data_aligner_nch

Parametrised N-channel data aligner, successor to the two-channel aligner: each channel writes into its own FIFO, and one output beat is emitted only once every channel holds at least one word. That beat carries one word from each channel, so arrival skew between channels is absorbed. It sits between independent input sources and a single downstream consumer, which can apply backpressure. Per-channel status flags are provided.

## Interface
- WIDTH_FIFO, 8: data width per channel, bits.
- DEPTH, 8: words per channel FIFO; power of two, ≥2.
- N_CH, 4: number of channels, ≥2.
- clk  in  1  clock, all logic on rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- data_i  in  N_CH*WIDTH_FIFO  channel k at bits [k*WIDTH_FIFO +: WIDTH_FIFO].
- vld_i  in  N_CH  per-channel write strobe.
- rdy_i  in  1  downstream ready.
- data_o  out  N_CH*WIDTH_FIFO  aligned beat, same packing as data_i.
- vld_o  out  1  data_o valid.
- full_o  out  N_CH  channel FIFO holds DEPTH words.
- empty_o  out  N_CH  channel FIFO holds 0 words.
- ovf_o  out  N_CH  sticky overflow flag; present only with the configuration macro.
- ovf_clr_i  in  1  clears ovf_o; present only with the configuration macro.

## Operation
- Each channel has a FIFO with a $clog2(DEPTH)+1-bit count and wrapping read/write pointers.
- Channel k performs a write when vld_i[k]=1 and either count<DEPTH, or count==DEPTH and a pop occurs in the same cycle.
- If vld_i[k]=1 and the write is not performed, the word is dropped. The FIFO contents are unchanged.
- Pop condition: all FIFOs non-empty and (vld_o==0 or rdy_i==1).
- A pop removes one word from every FIFO at the same time and loads those words into the data_o register. vld_o is then set to 1.
- If rdy_i==1 and vld_o==1 but no pop occurs, vld_o is cleared. data_o holds its last value.
- If vld_o==1 and rdy_i==0, data_o and vld_o are held stable. No pop occurs.
- On a simultaneous write and pop on one channel, the count is unchanged and both pointers advance.
- Output register state machine:
  - IDLE (vld_o=0) → VALID when the pop condition is true.
  - VALID → VALID on rdy_i with a pop.
  - VALID → IDLE on rdy_i without a pop.
- full_o and empty_o are combinational from the registered counts.
- Reset (asynchronous, any time):
  - Counts and pointers go to 0.
  - data_o=0, vld_o=0.
  - full_o=0, empty_o=all ones, ovf_o=0.
  - Data in flight is discarded.

## Timing
- A write sampled at edge E0 makes the word visible at E0+.
- The earliest pop is at edge E1, so vld_o=1 after E1. Minimum latency from the last channel's arrival to vld_o is 2 cycles.
- Sustained throughput is one beat per cycle when all channels write every cycle and rdy_i is held at 1.
- A drop decision at a full FIFO uses the same-cycle pop condition. The pop condition depends on rdy_i, so there is a combinational path from rdy_i to the write enables.

## Configuration
- DATA_ALIGNER_NCH_OVF_EN defined:
  - ovf_o and ovf_clr_i exist.
  - ovf_o[k] is set at the edge where channel k drops a word, and is held until ovf_clr_i=1.
  - ovf_clr_i clears the flags at the next edge. A drop in that same cycle wins: the flag stays set.
- Not defined: the ports are absent and drops are silent. All other behaviour is identical.

## Test plan
- Reset mid-stream:
  - Stimulus: assert aresetn=0 while vld_o=1 and the FIFOs are partially filled.
  - Response: outputs take their reset values immediately. After release, the first beat contains only post-reset writes.
- Skew absorption:
  - Stimulus: N_CH=4; channel 0 writes 0x11,0x12,0x13 at cycles 0–2; channels 1–3 write 0x21/0x31/0x41, 0x22/0x32/0x42, 0x23/0x33/0x43 at cycles 3–5; rdy_i=1.
  - Response: vld_o rises after the edge at cycle 4. The first beat is {0x41,0x31,0x21,0x11}, followed by two more aligned beats.
- Backpressure:
  - Stimulus: rdy_i=0 for 5 cycles while vld_o=1.
  - Response: data_o is stable for all 5 cycles. No words are lost while the FIFO count stays below DEPTH.
- Full and drop:
  - Stimulus: DEPTH=8; channel 0 writes 10 words while channel 1 stays idle.
  - Response: full_o[0]=1 after the 8th word. Words 9–10 are dropped and ovf_o[0]=1 (macro defined). ovf_clr_i clears the flag.
- Write to a full FIFO with a simultaneous pop:
  - Stimulus: all channels full and rdy_i=1.
  - Response: writing to every channel each cycle sustains one beat per cycle, with no drops and no overflow.
- Empty boundary:
  - Stimulus: one channel with empty_o=1 and all others full.
  - Response: vld_o stays 0, and no pop occurs until that channel is written.
